riscv_dmem_responder: RTL and testbench
=======================================

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit memory words (power of two).
REQ-002 The block SHALL have parameter LATENCY, default 2, giving the number of wait cycles between request accept and response (range 0-15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU presents a load/store request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_funct3, input, 3 bits: RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the CPU accepts the response.
REQ-013 The block SHALL have port rsp_rdata, output, 32 bits: load data, extended to 32 bits; 0 for stores and errors.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the access was misaligned, out of range or used an illegal funct3.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid && req_ready; all request fields are captured into registers at that edge.
REQ-018 On accept, the FSM SHALL go to WAIT when LATENCY > 0 (counter loaded with LATENCY-1), otherwise directly to RESP.
REQ-019 In WAIT the counter SHALL decrement each cycle; at 0 the FSM goes to RESP on the next edge.
REQ-020 rsp_valid SHALL rise exactly LATENCY+1 cycles after the accept edge.
REQ-021 The memory access (read or write commit) SHALL occur on the edge that enters RESP.
REQ-022 rsp_valid, rsp_rdata and rsp_err SHALL be registered and held stable in RESP until rsp_valid && rsp_ready.
REQ-023 When rsp_valid && rsp_ready, the FSM SHALL return to IDLE; no request is accepted on that same edge.
REQ-024 Exactly one request SHALL be outstanding at a time.
REQ-025 Loads SHALL select the lane by addr[1:0]: B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-026 Stores SHALL write only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes) from the low bits of wdata.
REQ-027 Misalignment (H/HU with addr[0]=1, W with addr[1:0]!=0), a word index >= DEPTH_WORDS, or funct3 in {011,110,111} (or 1xx on a store) SHALL set rsp_err=1 and rsp_rdata=0, with no memory write.
REQ-028 Word index SHALL be addr[31:2]; no wrap-around, so out-of-range addresses error per REQ-027.
REQ-029 Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by rst.

Reset
REQ-030 While rst=1 at an edge: the FSM goes to IDLE, the counter to 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=1 after the edge.
REQ-031 A reset in WAIT SHALL drop the pending request; an uncommitted store never writes memory.
REQ-032 A reset in RESP SHALL discard the response; an already-committed store remains in memory.
REQ-033 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-034 The shared package riscv_pkg SHALL hold the funct3 width constants and the FSM state typedef.
REQ-035 One combinational sub-module, dmem_lane_fmt, SHALL compute byte enables, the shifted store data, load extraction/extension and misalignment detection.
REQ-036 The memory array SHALL be a synchronous-write register array inside riscv_dmem_responder.

Verification
REQ-037 With LATENCY=2: SW addr 0x10, wdata 0xDEADBEEF, then LW addr 0x10 -> rsp_valid 3 cycles after each accept, and the load returns 0xDEADBEEF with rsp_err=0.
REQ-038 After REQ-037: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-039 SH addr 0x11 -> rsp_err=1; a following LW 0x10 still returns 0xDEADBEEF; LW addr 4*DEPTH_WORDS -> rsp_err=1 and rsp_rdata=0.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; rsp_ready=1 -> IDLE on the next edge.
REQ-041 SW 0x20 with 0x12345678, with rst asserted in WAIT -> no response, req_ready=1 after reset, and a later LW 0x20 returns the previous contents rather than 0x12345678.
REQ-042 With LATENCY=0, back-to-back requests and rsp_ready held at 1 -> one response every 2 cycles, and rsp_valid rises 1 cycle after each accept.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 data-memory definitions: funct3 width codes and the responder FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for RV32 loads/stores: enables, store replication, load extension, alignment checks.
module dmem_lane_fmt
  import riscv_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext,
  output logic        misalign,
  output logic        bad_funct3
);

  logic [31:0] shifted;

  always_comb begin
    shifted    = rword >> {addr_lo, 3'b000};
    be         = '0;
    wdata_sh   = '0;
    rdata_ext  = '0;
    misalign   = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        be         = 4'b0001 << addr_lo;
        rdata_ext  = {24'b0, shifted[7:0]};
        bad_funct3 = we;
      end
      F3_H: begin
        be        = 4'b0011 << addr_lo;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      F3_HU: begin
        be         = 4'b0011 << addr_lo;
        rdata_ext  = {16'b0, shifted[15:0]};
        misalign   = addr_lo[0];
        bad_funct3 = we;
      end
      F3_W: begin
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
        misalign  = |addr_lo;
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_dmem_responder.sv
// Single-outstanding RV32 data-memory responder with fixed response latency and byte-lane access.
module riscv_dmem_responder
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [2:0]  cap_f3;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        acc_we, acc_err, oor;
  logic [31:0] acc_addr, acc_wdata;
  logic [2:0]  acc_f3;
  logic [AW-1:0] widx;
  logic [3:0]  be;
  logic [31:0] wdata_sh, rdata_ext;
  logic        misalign, bad_funct3;

  assign accept     = req_valid && req_ready;
  assign enter_resp = (state_nxt == ST_RESP) && (state != ST_RESP);

  // With LATENCY=0 the access happens on the accept edge, so it must use the live request fields.
  assign acc_we    = (state == ST_IDLE) ? req_we     : cap_we;
  assign acc_addr  = (state == ST_IDLE) ? req_addr   : cap_addr;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata  : cap_wdata;
  assign acc_f3    = (state == ST_IDLE) ? req_funct3 : cap_f3;

  assign oor     = |acc_addr[31:AW+2];
  assign widx    = acc_addr[AW+1:2];
  assign acc_err = misalign || bad_funct3 || oor;

  dmem_lane_fmt u_fmt (
    .addr_lo    (acc_addr[1:0]),
    .funct3     (acc_f3),
    .we         (acc_we),
    .wdata      (acc_wdata),
    .rword      (mem[widx]),
    .be         (be),
    .wdata_sh   (wdata_sh),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign),
    .bad_funct3 (bad_funct3)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) state_nxt = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_f3    <= '0;
    end else begin
      if (accept) begin
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_f3    <= req_funct3;
        cnt       <= CNT_INIT;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (acc_err || acc_we) ? '0 : rdata_ext;
      end else if (state == ST_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Memory is never cleared; a store commits only on an un-reset edge entering RESP.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: LATENCY=2 and LATENCY=0 instances against a byte-array reference model.
module tb_riscv_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT0  = 2;
  localparam int LAT1  = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]       req_valid, req_we, rsp_ready;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][2:0]  req_funct3;
  logic [1:0]       req_ready, rsp_valid, rsp_err;
  logic [1:0][31:0] rsp_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  riscv_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  function automatic int latof(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%h want=%h t=%0t", nm, i, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory plus one pending transaction per instance.
  logic [7:0]  mm [2][4*DEPTH];
  int          st [2];          // 0 free, 1 accepted/not yet answered, 2 answer presented
  int          resp_edge [2];
  logic [31:0] e_rd [2];
  logic        e_err [2];
  logic        pw [2];
  logic [31:0] pa [2], pwd [2];
  int          pn [2];
  int          ecount = 0;

  function automatic void model_req(input int i, input logic we, input logic [31:0] a,
                                    input logic [2:0] f3, output logic [31:0] rd, output logic err);
    int n;
    longint unsigned v;
    n = nbytes(f3);
    err = (f3 == 3'd3) || (f3 >= 3'd6) || (we && f3 >= 3'd4) ||
          ((a % n) != 0) || ((a / 4) >= DEPTH);
    rd = '0;
    if (!err && !we) begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(mm[i][int'(a) + k]) << (8 * k));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      rd = v[31:0];
    end
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) st[i] = 0;
      else begin
        if (st[i] == 0 && req_valid[i]) begin
          model_req(i, req_we[i], req_addr[i], req_funct3[i], e_rd[i], e_err[i]);
          pw[i] = req_we[i] && !e_err[i];
          pa[i] = req_addr[i];
          pwd[i] = req_wdata[i];
          pn[i] = nbytes(req_funct3[i]);
          resp_edge[i] = ecount + latof(i);
          st[i] = 1;
        end else if (st[i] == 2 && rsp_ready[i]) begin
          st[i] = 0;
        end
        if (st[i] == 1 && ecount == resp_edge[i]) begin
          if (pw[i])
            for (int k = 0; k < pn[i]; k++) mm[i][int'(pa[i]) + k] = 8'(pwd[i] >> (8 * k));
          st[i] = 2;
        end
      end
    end
    ecount++;
  end

  always @(negedge clk) begin
    if (ecount > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk("req_ready", i, 32'(req_ready[i]), 32'(st[i] == 0));
        chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(st[i] == 2));
        if (st[i] == 2) begin
          chk("rsp_rdata", i, rsp_rdata[i], e_rd[i]);
          chk("rsp_err", i, 32'(rsp_err[i]), 32'(e_err[i]));
        end
      end
    end
  end

  // Issue one request, check latency and optional literal result, optionally stall the response.
  task automatic do_req(input int i, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, input bit lit, input logic [31:0] lrd,
                        input logic lerr, input int hold);
    int k;
    bit got;
    logic [31:0] first;
    @(negedge clk);
    k = 0;
    while (!req_ready[i] && k < 100) begin @(negedge clk); k++; end
    if (!req_ready[i]) begin chk("ready_timeout", i, 32'(req_ready[i]), 32'd1); return; end
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_wdata[i] = wd; req_funct3[i] = f3;
    rsp_ready[i] = (hold == 0);
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
    got = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rsp_valid[i]) begin got = 1; break; end
    end
    if (!got) begin chk("rsp_timeout", i, 32'(rsp_valid[i]), 32'd1); rsp_ready[i] = 1'b1; return; end
    chk("latency", i, 32'(k), 32'(latof(i) + 1));
    if (lit) begin
      chk("lit_rdata", i, rsp_rdata[i], lrd);
      chk("lit_err", i, 32'(rsp_err[i]), 32'(lerr));
    end
    first = rsp_rdata[i];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", i, 32'(rsp_valid[i]), 32'd1);
      chk("hold_rdata", i, rsp_rdata[i], first);
      chk("hold_ready", i, 32'(req_ready[i]), 32'd0);
    end
    rsp_ready[i] = 1'b1;
    @(posedge clk);
    if (hold > 0) begin
      @(negedge clk);
      chk("idle_after_hold", i, 32'(req_ready[i]), 32'd1);
    end
  endtask

  logic [31:0] initw [2][DEPTH];
  logic [31:0] r;
  bit          pat [10];
  int          k0;

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_funct3 = '0; rsp_ready = '1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
      chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
      chk("rst_rsp_err", i, 32'(rsp_err[i]), 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < DEPTH; w++) begin
        initw[i][w] = $urandom;
        do_req(i, 1'b1, 32'(4 * w), initw[i][w], 3'b010, 1, 32'd0, 1'b0, 0);
      end

    do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 1, 32'hDEADBEEF, 1'b0, 0);
    do_req(0, 1'b0, 32'h13, 32'h0, 3'b000, 1, 32'hFFFFFFDE, 1'b0, 0);
    do_req(0, 1'b0, 32'h13, 32'h0, 3'b100, 1, 32'h000000DE, 1'b0, 0);
    do_req(0, 1'b0, 32'h12, 32'h0, 3'b001, 1, 32'hFFFFDEAD, 1'b0, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b101, 1, 32'h0000BEEF, 1'b0, 0);
    do_req(0, 1'b1, 32'h11, 32'h0000CAFE, 3'b001, 1, 32'h0, 1'b1, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 1, 32'hDEADBEEF, 1'b0, 0);
    do_req(0, 1'b0, 32'(4 * DEPTH), 32'h0, 3'b010, 1, 32'h0, 1'b1, 0);
    do_req(0, 1'b1, 32'h14, 32'hAABBCCDD, 3'b100, 1, 32'h0, 1'b1, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b011, 1, 32'h0, 1'b1, 0);
    do_req(0, 1'b1, 32'h15, 32'h00000077, 3'b000, 1, 32'h0, 1'b0, 0);
    do_req(0, 1'b0, 32'h14, 32'h0, 3'b100, 1, 32'(initw[0][5][7:0]), 1'b0, 0);
    do_req(0, 1'b0, 32'h15, 32'h0, 3'b100, 1, 32'h00000077, 1'b0, 0);
    do_req(0, 1'b0, 32'h10, 32'h0, 3'b010, 1, 32'hDEADBEEF, 1'b0, 5);

    // Store interrupted by reset while waiting: must never reach memory.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    req_funct3[0] = 3'b010;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstwait_rsp_valid", 0, 32'(rsp_valid[0]), 32'd0);
    chk("rstwait_req_ready", 0, 32'(req_ready[0]), 32'd1);
    chk("rstwait_rsp_rdata", 0, rsp_rdata[0], 32'd0);
    chk("rstwait_rsp_err", 0, 32'(rsp_err[0]), 32'd0);
    do_req(0, 1'b0, 32'h20, 32'h0, 3'b010, 1, initw[0][8], 1'b0, 0);

    // LATENCY=0: requests held back-to-back, response every other cycle.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h8; req_funct3[1] = 3'b010;
    rsp_ready[1] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      pat[j] = rsp_valid[1];
    end
    req_valid[1] = 1'b0;
    for (int j = 0; j < 10; j++) chk("b2b_pattern", 1, 32'(pat[j]), 32'((j % 2) == 0));
    do_req(1, 1'b0, 32'h8, 32'h0, 3'b010, 1, initw[1][2], 1'b0, 0);

    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst = ($urandom % 150 == 0);
      for (int i = 0; i < 2; i++) begin
        req_valid[i] = ($urandom % 4 != 0);
        req_we[i] = $urandom % 2;
        req_funct3[i] = 3'($urandom % 8);
        k0 = $urandom % 16;
        r = $urandom;
        if (k0 == 0) req_addr[i] = r;
        else if (k0 == 1) req_addr[i] = 32'(4 * DEPTH) + (r % 16);
        else req_addr[i] = r % (4 * DEPTH);
        req_wdata[i] = $urandom;
        rsp_ready[i] = ($urandom % 3 != 0);
      end
    end
    @(negedge clk);
    rst = 1'b0; req_valid = '0; rsp_ready = '1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout got=running want=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
